// File: rtl/i2c_cfg_sequencer.sv
// Walks a {reg_addr, reg_data} config LUT and issues each entry as one I2C write, with power-up
// and in-table ms delays, NACK retry and done/error status. Option macro: CFG_READBACK_VERIFY_EN.
module i2c_cfg_sequencer #(
  parameter int          CLK_FREQ      = 50_000_000,
  parameter int          REG_ADDR_W    = 16,
  parameter int          REG_DATA_W    = 8,
  parameter int          IDX_W         = 8,
  parameter int          INIT_DELAY_MS = 20,
  parameter logic [15:0] DELAY_ADDR    = 16'hFFFF,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  output logic [IDX_W-1:0]                 lut_index,
  input  logic [REG_ADDR_W+REG_DATA_W-1:0] lut_data,
  input  logic [IDX_W-1:0]                 lut_size,
  output logic                             i2c_req,
  output logic [REG_ADDR_W-1:0]            i2c_addr,
  output logic [REG_DATA_W-1:0]            i2c_wdata,
  output logic                             i2c_rw,
  input  logic [REG_DATA_W-1:0]            i2c_rdata,
  input  logic                             i2c_done,
  input  logic                             i2c_nack,
  output logic                             cfg_busy,
  output logic                             cfg_done,
  output logic                             cfg_error,
  output logic [IDX_W-1:0]                 err_index
);
  localparam int TICK_DIV = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RTRY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [REG_ADDR_W-1:0] DLY_ADDR = REG_ADDR_W'(DELAY_ADDR);

  typedef enum logic [3:0] {
    PWRUP, IDLE, FETCH, LATCH, ISSUE, WAIT, DELAY, NEXT, DONE, ERROR
`ifdef CFG_READBACK_VERIFY_EN
    , RD_ISSUE, RD_WAIT
`endif
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx_n, err_idx_n;
  logic [REG_ADDR_W-1:0]   addr_n, lut_addr;
  logic [REG_DATA_W-1:0]   data_n, lut_wdat;
  logic [RTRY_W-1:0]       retry, retry_n;
  logic [15:0]             ms_cnt, ms_n;
  logic [TICK_W-1:0]       tick_cnt;
  logic                    tick, req_n, fail, last_entry;

  assign lut_addr   = lut_data[REG_ADDR_W+REG_DATA_W-1:REG_DATA_W];
  assign lut_wdat   = lut_data[REG_DATA_W-1:0];
  assign tick       = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign last_entry = ({1'b0, lut_index} + (IDX_W+1)'(1)) >= {1'b0, lut_size};

`ifdef CFG_READBACK_VERIFY_EN
  logic rw_q, rw_n;
  assign i2c_rw = rw_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^i2c_rdata;
  assign i2c_rw       = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    idx_n     = lut_index;
    addr_n    = i2c_addr;
    data_n    = i2c_wdata;
    retry_n   = retry;
    ms_n      = ms_cnt;
    req_n     = i2c_req;
    err_idx_n = err_index;
    fail      = 1'b0;
`ifdef CFG_READBACK_VERIFY_EN
    rw_n      = rw_q;
`endif
    case (state)
      PWRUP: begin
        if (ms_cnt >= 16'(INIT_DELAY_MS)) begin
          ms_n    = '0;
          idx_n   = '0;
          state_n = (lut_size == '0) ? DONE : FETCH;
        end else if (tick) begin
          ms_n = ms_cnt + 16'd1;
        end
      end
      IDLE, DONE, ERROR: begin
        if (cfg_start) begin
          retry_n = '0;
          idx_n   = '0;
          state_n = (lut_size == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        addr_n  = lut_addr;
        data_n  = lut_wdat;
        ms_n    = '0;
        state_n = (lut_addr == DLY_ADDR) ? DELAY : ISSUE;
      end
      // Delay entries reuse the latched data register as the ms count.
      DELAY: begin
        if (ms_cnt >= 16'(i2c_wdata)) begin
          ms_n    = '0;
          state_n = NEXT;
        end else if (tick) begin
          ms_n = ms_cnt + 16'd1;
        end
      end
      ISSUE: begin
        req_n   = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (i2c_nack) begin
          req_n = 1'b0;
          fail  = 1'b1;
        end else if (i2c_done) begin
          req_n = 1'b0;
`ifdef CFG_READBACK_VERIFY_EN
          state_n = RD_ISSUE;
`else
          state_n = NEXT;
`endif
        end
      end
`ifdef CFG_READBACK_VERIFY_EN
      RD_ISSUE: begin
        req_n   = 1'b1;
        rw_n    = 1'b1;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (i2c_nack || i2c_done) begin
          req_n = 1'b0;
          rw_n  = 1'b0;
          if (i2c_nack || (i2c_rdata != i2c_wdata)) fail = 1'b1;
          else state_n = NEXT;
        end
      end
`endif
      NEXT: begin
        retry_n = '0;
        if (last_entry) begin
          state_n = DONE;
        end else begin
          idx_n   = lut_index + IDX_W'(1);
          state_n = FETCH;
        end
      end
      default: state_n = PWRUP;
    endcase

    // A failed attempt goes back through ISSUE so i2c_req drops for at least one cycle.
    if (fail) begin
      if (retry < RTRY_W'(MAX_RETRY)) begin
        retry_n = retry + RTRY_W'(1);
        state_n = ISSUE;
      end else begin
        err_idx_n = lut_index;
        state_n   = ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PWRUP;
      lut_index <= '0;
      i2c_addr  <= '0;
      i2c_wdata <= '0;
      i2c_req   <= 1'b0;
      retry     <= '0;
      ms_cnt    <= '0;
      tick_cnt  <= '0;
      err_index <= '0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
`ifdef CFG_READBACK_VERIFY_EN
      rw_q      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      lut_index <= idx_n;
      i2c_addr  <= addr_n;
      i2c_wdata <= data_n;
      i2c_req   <= req_n;
      retry     <= retry_n;
      ms_cnt    <= ms_n;
      tick_cnt  <= tick ? '0 : tick_cnt + TICK_W'(1);
      err_index <= err_idx_n;
      cfg_busy  <= !((state_n == IDLE) || (state_n == DONE) || (state_n == ERROR));
      cfg_done  <= (state_n == DONE);
      cfg_error <= (state_n == ERROR);
`ifdef CFG_READBACK_VERIFY_EN
      rw_q      <= rw_n;
`endif
    end
  end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: an I2C responder logs requests; a table-level model predicts them.
module tb_i2c_cfg_sequencer;
  localparam int CLK_FREQ = 10_000;  // 10 clocks per ms keeps delays short
  localparam int CPM      = CLK_FREQ / 1000;
  localparam int INIT_MS  = 4;
  localparam int AW = 16, DW = 8, IW = 8, MAXR = 3;

  logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0;
  logic [IW-1:0] lut_index, lut_size, err_index;
  logic [AW+DW-1:0] lut_data;
  logic i2c_req, i2c_rw, i2c_done, i2c_nack, cfg_busy, cfg_done, cfg_error;
  logic [AW-1:0] i2c_addr;
  logic [DW-1:0] i2c_wdata, i2c_rdata;

  logic [AW+DW-1:0] lut_mem [16];
  int nack_left [16];
  int both_left [16];
  int resp_lat = 10;
  int vectors = 0, errors = 0, cyc = 0;

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            log_start [$];
  int            log_end [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_err;
  int            exp_err_idx;

  i2c_cfg_sequencer #(
    .CLK_FREQ(CLK_FREQ), .REG_ADDR_W(AW), .REG_DATA_W(DW), .IDX_W(IW),
    .INIT_DELAY_MS(INIT_MS), .DELAY_ADDR(16'hFFFF), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .lut_index(lut_index),
    .lut_data(lut_data), .lut_size(lut_size), .i2c_req(i2c_req), .i2c_addr(i2c_addr),
    .i2c_wdata(i2c_wdata), .i2c_rw(i2c_rw), .i2c_rdata(i2c_rdata), .i2c_done(i2c_done),
    .i2c_nack(i2c_nack), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .err_index(err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign lut_data = lut_mem[lut_index[3:0]];

  // I2C responder: answers each request after resp_lat cycles, consuming the per-entry fault plan.
  initial begin : responder
    logic in_xfer, drop_chk;
    int lat, cur;
    in_xfer = 1'b0; drop_chk = 1'b0; lat = 0; cur = 0;
    i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = '0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (drop_chk) begin
        drop_chk = 1'b0;
        vectors++;
        if (i2c_req !== 1'b0) begin
          errors++;
          $display("FAIL req_drop: i2c_req=%b the cycle after a response, required 0", i2c_req);
        end
      end else if (i2c_req !== 1'b1) begin
        in_xfer = 1'b0;
      end else if (!in_xfer) begin
        in_xfer = 1'b1;
        lat = resp_lat;
        cur = int'(lut_index[3:0]);
        log_addr.push_back(i2c_addr);
        log_data.push_back(i2c_wdata);
        log_start.push_back(cyc);
      end else if (lat > 1) begin
        lat--;
      end else begin
        vectors++;
        if (i2c_addr !== log_addr[$] || i2c_wdata !== log_data[$] || i2c_rw !== 1'b0) begin
          errors++;
          $display("FAIL req_stable: addr=%h data=%h rw=%b at response, required %h %h 0",
                   i2c_addr, i2c_wdata, i2c_rw, log_addr[$], log_data[$]);
        end
        if (both_left[cur] > 0) begin
          both_left[cur]--; i2c_done = 1'b1; i2c_nack = 1'b1;
        end else if (nack_left[cur] > 0) begin
          nack_left[cur]--; i2c_nack = 1'b1;
        end else begin
          i2c_done = 1'b1;
        end
        log_end.push_back(cyc);
        in_xfer = 1'b0;
        drop_chk = 1'b1;
      end
    end
  end

  // Reference: every non-delay entry costs (failures + 1) writes, capped at MAX_RETRY+1 and then error.
  task automatic build_expected(input int size);
    exp_addr.delete(); exp_data.delete();
    exp_err = 1'b0; exp_err_idx = 0;
    for (int i = 0; i < size; i++) begin
      int fails, tries;
      fails = nack_left[i] + both_left[i];
      if (lut_mem[i][AW+DW-1:DW] == 16'hFFFF) continue;
      tries = (fails > MAXR) ? MAXR + 1 : fails + 1;
      repeat (tries) begin
        exp_addr.push_back(lut_mem[i][AW+DW-1:DW]);
        exp_data.push_back(lut_mem[i][DW-1:0]);
      end
      if (fails > MAXR) begin exp_err = 1'b1; exp_err_idx = i; break; end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 16; i++) begin nack_left[i] = 0; both_left[i] = 0; end
    log_addr.delete(); log_data.delete(); log_start.delete(); log_end.delete();
  endtask

  task automatic fill_table(input int size);
    for (int i = 0; i < 16; i++)
      lut_mem[i] = {16'($urandom_range(0, 65534)), 8'($urandom())};
    lut_size = IW'(size);
  endtask

  task automatic do_reset(output int rel);
    @(negedge clk); rst_n = 1'b0; cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rel = cyc;
  endtask

  task automatic pulse_start();
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < 20000) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required done or error", tag, cfg_busy, n);
    end
  endtask

  task automatic test_reset();
    int rel;
    clear_all(); fill_table(3); resp_lat = 10;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({i2c_req, i2c_rw, cfg_busy, cfg_done, cfg_error, lut_index, err_index, i2c_addr, i2c_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b busy=%b done=%b err=%b idx=%h addr=%h, required all 0",
               i2c_req, cfg_busy, cfg_done, cfg_error, lut_index, i2c_addr);
    end
    rst_n = 1'b1; rel = cyc;
    @(negedge clk);
    vectors++;
    if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL pwrup_busy: busy=%b done=%b, required 1 0", cfg_busy, cfg_done);
    end
  endtask

  task automatic test_basic();
    int rel;
    clear_all(); fill_table(3); resp_lat = 10;
    build_expected(3);
    do_reset(rel);
    wait_end("basic");
    vectors++;
    if (log_addr.size() != 3) begin
      errors++; $display("FAIL basic_count: %0d requests, required 3", log_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      vectors++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL basic_req%0d: %h/%h, required %h/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (log_start.size() > 0) begin
      vectors++;
      if (log_start[0] - rel < (INIT_MS - 1) * CPM || log_start[0] - rel > (INIT_MS + 1) * CPM + 8) begin
        errors++;
        $display("FAIL init_delay: first request %0d cycles after reset, required about %0d", log_start[0] - rel, INIT_MS * CPM);
      end
    end
    vectors++;
    if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || cfg_error !== 1'b0) begin
      errors++; $display("FAIL basic_status: done=%b busy=%b err=%b, required 1 0 0", cfg_done, cfg_busy, cfg_error);
    end
  endtask

  task automatic test_delay();
    int gap;
    clear_all(); fill_table(3); resp_lat = 10;
    lut_mem[1] = {16'hFFFF, 8'h05};
    build_expected(3);
    pulse_start();
    wait_end("delay");
    vectors++;
    if (log_addr.size() != exp_addr.size() || log_addr.size() != 2) begin
      errors++; $display("FAIL delay_count: %0d requests, required 2", log_addr.size());
    end else begin
      vectors++;
      if (log_addr[0] !== exp_addr[0] || log_addr[1] !== exp_addr[1]) begin
        errors++; $display("FAIL delay_order: %h %h, required %h %h", log_addr[0], log_addr[1], exp_addr[0], exp_addr[1]);
      end
      gap = log_start[1] - log_end[0];
      vectors++;
      if (gap < 4 * CPM || gap > 6 * CPM + 8) begin
        errors++; $display("FAIL delay_gap: %0d cycles between writes, required 5 ms (%0d) +/- 1 ms", gap, 5 * CPM);
      end
    end
  endtask

  task automatic test_retry_ok();
    clear_all(); fill_table(3); resp_lat = 10;
    nack_left[2] = 3;
    build_expected(3);
    pulse_start();
    wait_end("retry_ok");
    vectors++;
    if (log_addr.size() != 6) begin
      errors++; $display("FAIL retry_ok_count: %0d requests, required 6", log_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      vectors++;
      if (log_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL retry_ok_req%0d: %h, required %h", i, log_addr[i], exp_addr[i]);
      end
    end
    vectors++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      errors++; $display("FAIL retry_ok_status: done=%b err=%b, required 1 0", cfg_done, cfg_error);
    end
  endtask

  task automatic test_retry_err();
    int n;
    clear_all(); fill_table(3); resp_lat = 10;
    nack_left[2] = 4;
    build_expected(3);
    pulse_start();
    wait_end("retry_err");
    vectors++;
    if (cfg_error !== 1'b1 || err_index !== 8'd2 || cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL retry_err_status: err=%b idx=%0d done=%b busy=%b, required 1 2 0 0", cfg_error, err_index, cfg_done, cfg_busy);
    end
    n = log_addr.size();
    repeat (200) @(negedge clk);
    vectors++;
    if (log_addr.size() != exp_addr.size() || n != 6) begin
      errors++; $display("FAIL retry_err_count: %0d then %0d requests, required 6", n, log_addr.size());
    end
    vectors++;
    if (cfg_error !== 1'b1) begin
      errors++; $display("FAIL error_sticky: err=%b, required 1", cfg_error);
    end
    clear_all();
    build_expected(3);
    pulse_start();
    vectors++;
    if (cfg_error !== 1'b0 || cfg_busy !== 1'b1) begin
      errors++; $display("FAIL restart_clear: err=%b busy=%b, required 0 1", cfg_error, cfg_busy);
    end
    wait_end("restart");
    vectors++;
    if (log_addr.size() != 3 || log_addr[0] !== exp_addr[0] || cfg_done !== 1'b1) begin
      errors++; $display("FAIL restart_run: %0d requests done=%b, required 3 starting at %h with done=1", log_addr.size(), cfg_done, exp_addr[0]);
    end
  endtask

  task automatic test_both();
    clear_all(); fill_table(2); resp_lat = 3;
    both_left[0] = 1;
    build_expected(2);
    pulse_start();
    wait_end("both");
    vectors++;
    if (log_addr.size() != 3 || log_addr[0] !== log_addr[1] || log_addr[0] !== exp_addr[0]) begin
      errors++; $display("FAIL done_and_nack: %0d requests, required 3 with entry 0 issued twice", log_addr.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int size;
      clear_all();
      size = $urandom_range(1, 7);
      fill_table(size);
      resp_lat = $urandom_range(1, 6);
      for (int i = 0; i < size; i++) begin
        if ($urandom_range(0, 4) == 0) lut_mem[i] = {16'hFFFF, 8'($urandom_range(0, 2))};
        if ($urandom_range(0, 9) < 3) nack_left[i] = $urandom_range(1, 4);
        if ($urandom_range(0, 9) == 0) both_left[i] = 1;
      end
      build_expected(size);
      pulse_start();
      wait_end("random");
      vectors++;
      if (log_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_count: %0d requests, required %0d", it, log_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
        vectors++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL rand%0d_req%0d: %h/%h, required %h/%h", it, i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
        end
      end
      vectors++;
      if (cfg_error !== exp_err || cfg_done !== !exp_err || (exp_err && err_index !== IW'(exp_err_idx))) begin
        errors++;
        $display("FAIL rand%0d_status: err=%b done=%b idx=%0d, required err=%b idx=%0d", it, cfg_error, cfg_done, err_index, exp_err, exp_err_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_all(); fill_table(3); resp_lat = 10;
    pulse_start();
    n = 0;
    while (i2c_req !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({i2c_req, cfg_busy, cfg_done, cfg_error, lut_index, i2c_addr, i2c_wdata} !== '0 || n >= 2000) begin
      errors++;
      $display("FAIL reset_in_wait: req=%b busy=%b idx=%h addr=%h (waited %0d), required all 0", i2c_req, cfg_busy, lut_index, i2c_addr, n);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_empty();
    int rel;
    clear_all(); fill_table(0);
    do_reset(rel);
    wait_end("empty");
    vectors++;
    if (log_addr.size() != 0 || cfg_done !== 1'b1 || cfg_busy !== 1'b0) begin
      errors++; $display("FAIL empty_table: %0d requests done=%b busy=%b, required 0 1 0", log_addr.size(), cfg_done, cfg_busy);
    end
    pulse_start();
    repeat (20) @(negedge clk);
    vectors++;
    if (log_addr.size() != 0 || cfg_done !== 1'b1) begin
      errors++; $display("FAIL empty_restart: %0d requests done=%b, required 0 1", log_addr.size(), cfg_done);
    end
  endtask

  initial begin
    lut_size = '0;
    test_reset();
    test_basic();
    test_delay();
    test_retry_ok();
    test_retry_err();
    test_both();
    test_random();
    test_reset_mid();
    test_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
